// File: rtl/alu_result_queue.sv
// rtl/alu_result_queue.sv - FIFO buffering ALU results with saturating error statistics
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [31:0]               in_c,
    input  logic [1:0]                in_error,
    input  logic [3:0]                in_opcode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_c,
    output logic [1:0]                out_error,
    output logic [3:0]                out_opcode,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    input  logic                      clr_stats,
    output logic [CNT_W-1:0]          ovf_cnt,
    output logic [CNT_W-1:0]          div0_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]      CNT_ONE  = 1;
    localparam logic [AW-1:0]    PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] STAT_MAX = '1;
    localparam logic [CNT_W-1:0] STAT_ONE = 1;

    // Entry layout: {opcode[37:34], error[33:32], c[31:0]}
    logic [37:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count_q;
    logic [37:0]   head;
    logic          push;
    logic          pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign head       = mem[rd_ptr];
    assign out_c      = empty ? 32'd0 : head[31:0];
    assign out_error  = empty ? 2'd0  : head[33:32];
    assign out_opcode = empty ? 4'd0  : head[37:34];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_opcode, in_error, in_c};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Clear takes priority over a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt  <= '0;
            div0_cnt <= '0;
        end else if (clr_stats) begin
            ovf_cnt  <= '0;
            div0_cnt <= '0;
        end else if (push) begin
            if (in_error[0] && ovf_cnt != STAT_MAX) begin
                ovf_cnt <= ovf_cnt + STAT_ONE;
            end
            if (in_error[1] && div0_cnt != STAT_MAX) begin
                div0_cnt <= div0_cnt + STAT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_queue.sv
// tb/tb_alu_result_queue.sv - self-checking bench for alu_result_queue
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_c = '0;
    logic [1:0]  in_error = '0;
    logic [3:0]  in_opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_c;
    logic [1:0]  out_error;
    logic [3:0]  out_opcode;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        clr_stats = 1'b0;
    logic [7:0]  ovf_cnt;
    logic [7:0]  div0_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [37:0] q[$];
    int          m_ovf = 0;
    int          m_div0 = 0;

    typedef struct {
        logic        v;
        logic [31:0] c;
        logic [1:0]  e;
        logic [3:0]  op;
        logic        rdy;
        logic        clr;
        int          exp_count;
        logic [31:0] exp_c;
        int          exp_ovf;
        int          exp_div0;
    } vec_t;

    vec_t tbl[12];

    alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_c(in_c), .in_error(in_error), .in_opcode(in_opcode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_error(out_error), .out_opcode(out_opcode),
        .count(count), .full(full), .empty(empty),
        .clr_stats(clr_stats), .ovf_cnt(ovf_cnt), .div0_cnt(div0_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [37:0] h;
        int n;
        n = q.size();
        h = (n > 0) ? q[0] : 38'd0;
        chk("count", 64'(count), 64'(n));
        chk("full", 64'(full), 64'(n == DEPTH));
        chk("empty", 64'(empty), 64'(n == 0));
        chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        chk("out_c", 64'(out_c), 64'(h[31:0]));
        chk("out_error", 64'(out_error), 64'(h[33:32]));
        chk("out_opcode", 64'(out_opcode), 64'(h[37:34]));
        chk("ovf_cnt", 64'(ovf_cnt), 64'(m_ovf));
        chk("div0_cnt", 64'(div0_cnt), 64'(m_div0));
    endtask

    task automatic step(input logic v, input logic [31:0] c, input logic [1:0] e,
                        input logic [3:0] op, input logic rdy, input logic clr);
        bit do_push;
        bit do_pop;
        in_valid  = v;
        in_c      = c;
        in_error  = e;
        in_opcode = op;
        out_ready = rdy;
        clr_stats = clr;
        do_push = v && (q.size() < DEPTH);
        do_pop  = rdy && (q.size() > 0);
        @(posedge clk);
        #1;
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back({op, e, c});
        if (clr) begin
            m_ovf = 0;
            m_div0 = 0;
        end else if (do_push) begin
            if (e[0] && m_ovf < SAT) m_ovf++;
            if (e[1] && m_div0 < SAT) m_div0++;
        end
        check_model();
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_div0 = 0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 32'd6, 2'b00, 4'd1,  1'b0, 1'b0, 1, 32'd6, 0, 0};
        tbl[1]  = '{1'b0, 32'd0, 2'b00, 4'd0,  1'b1, 1'b0, 0, 32'd0, 0, 0};
        tbl[2]  = '{1'b1, 32'd1, 2'b01, 4'd2,  1'b0, 1'b0, 1, 32'd1, 1, 0};
        tbl[3]  = '{1'b1, 32'd2, 2'b10, 4'd3,  1'b0, 1'b0, 2, 32'd1, 1, 1};
        tbl[4]  = '{1'b1, 32'd3, 2'b11, 4'd0,  1'b0, 1'b0, 3, 32'd1, 2, 2};
        tbl[5]  = '{1'b1, 32'd4, 2'b00, 4'd15, 1'b0, 1'b0, 4, 32'd1, 2, 2};
        tbl[6]  = '{1'b1, 32'd5, 2'b01, 4'd7,  1'b0, 1'b0, 4, 32'd1, 2, 2};
        tbl[7]  = '{1'b1, 32'd9, 2'b11, 4'd7,  1'b1, 1'b0, 3, 32'd2, 2, 2};
        tbl[8]  = '{1'b0, 32'd0, 2'b00, 4'd0,  1'b1, 1'b0, 2, 32'd3, 2, 2};
        tbl[9]  = '{1'b0, 32'd0, 2'b00, 4'd0,  1'b1, 1'b0, 1, 32'd4, 2, 2};
        tbl[10] = '{1'b1, 32'd7, 2'b01, 4'd6,  1'b1, 1'b1, 1, 32'd7, 0, 0};
        tbl[11] = '{1'b0, 32'd0, 2'b00, 4'd0,  1'b1, 1'b0, 0, 32'd0, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_out_c", 64'(out_c), 64'd0);
        check_model();

        // Directed table: single push/pop, fill to full, blocked push, drain, clear-wins
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].e, tbl[i].op, tbl[i].rdy, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
            chk($sformatf("tbl%0d_out_c", i), 64'(out_c), 64'(tbl[i].exp_c));
            chk($sformatf("tbl%0d_ovf", i), 64'(ovf_cnt), 64'(tbl[i].exp_ovf));
            chk($sformatf("tbl%0d_div0", i), 64'(div0_cnt), 64'(tbl[i].exp_div0));
        end

        // Streaming with no bubbles across pointer wrap
        step(1'b1, 32'd1, 2'b00, 4'd1, 1'b0, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            step(1'b1, 32'(i), 2'b00, 4'd1, 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_out_c", 64'(out_c), 64'(i));
        end
        step(1'b0, 32'd0, 2'b00, 4'd0, 1'b1, 1'b0);
        chk("stream_drained", 64'(empty), 64'd1);

        // Saturation of the overflow counter
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 32'(i), 2'b01, 4'd1, 1'b1, 1'b0);
        end
        chk("ovf_saturated", 64'(ovf_cnt), 64'(SAT));
        step(1'b0, 32'd0, 2'b00, 4'd0, 1'b1, 1'b0);

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'(100 + i), 2'b11, 4'd2, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_empty", 64'(empty), 64'd1);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        check_model();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 32'hABCD, 2'b10, 4'd9, 1'b0, 1'b0);
        chk("post_rst_out_c", 64'(out_c), 64'hABCD);
        step(1'b0, 32'd0, 2'b00, 4'd0, 1'b1, 1'b0);

        // Randomized traffic against the queue model
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom(), 2'($urandom()), 4'($urandom()),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Buffers results produced by the 16-bit combinational ALU breadboard (32-bit C, 2-bit error, 4-bit opcode) in a small synchronous FIFO with valid/ready handshakes on both sides. This lets a slow consumer such as a writeback or display stage drain results at its own pace. The block sits directly downstream of the ALU and also keeps saturating per-class error statistics: add/sub overflow (error[0]) and divide/modulus by zero (error[1]).

## Interface
- DEPTH, 4: number of entries; power of two, 2..16.
- CNT_W, 8: width of each saturating error counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  ALU result presented this cycle.
- in_ready  output  1  queue can accept this cycle.
- in_c  input  32  ALU result C.
- in_error  input  2  ALU error; bit0 = overflow, bit1 = div/mod by zero.
- in_opcode  input  4  opcode that produced the result.
- out_valid  output  1  head entry available.
- out_ready  input  1  consumer takes the head this cycle.
- out_c  output  32  head result.
- out_error  output  2  head error.
- out_opcode  output  4  head opcode.
- count  output  $clog2(DEPTH)+1  current occupancy.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- clr_stats  input  1  synchronous clear of the statistics counters.
- ovf_cnt  output  CNT_W  number of accepted entries with error[0] set.
- div0_cnt  output  CNT_W  number of accepted entries with error[1] set.

## Operation
- Storage: DEPTH x 38-bit register array holding {opcode, error, C}. Read pointer and write pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. A separate count register tracks occupancy.
- Push happens when in_valid && in_ready. The entry is written at wr_ptr and wr_ptr increments.
- Pop happens when out_valid && out_ready. rd_ptr increments.
- in_ready = !full. There is no pass-through when full: a same-cycle pop does not free a slot for that cycle's push.
- out_valid = !empty. out_c, out_error and out_opcode are read combinationally from mem[rd_ptr] and are held stable while out_valid && !out_ready.
- When empty, out_c, out_error and out_opcode drive 0. They never show stale array data.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop in the same cycle (only possible when 0 < count < DEPTH): count unchanged, both pointers advance.
- Statistics:
  - On each push, ovf_cnt += in_error[0] and div0_cnt += in_error[1].
  - Both counters saturate at 2^CNT_W−1.
  - clr_stats zeroes both counters. Clear wins over a simultaneous increment.
  - Statistics count pushes only; pops never affect them.
- Entries are stored without interpretation. Opcode values 0 and 6..15, and their C value, are queued unchanged.
- The in_* signals are sampled only on a push. Values presented while in_ready=0 are ignored.

## Timing
- Reset (async assert, sync release): rd_ptr = wr_ptr = count = 0, ovf_cnt = div0_cnt = 0. Outputs: in_ready=1, out_valid=0, full=0, empty=1, out_c=0, out_error=0, out_opcode=0. The array contents need not be reset.
- Reset asserted mid-operation discards all queued entries immediately (asynchronously). Handshakes in flight that cycle are lost.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N, i.e. in cycle N+1. The earliest pop is at edge N+1.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Pointer wrap from DEPTH−1 to 0 must preserve FIFO order.
- All outputs except out_c, out_error and out_opcode are registered or derived only from registered state. in_ready does not depend combinationally on out_ready.

## Test plan
- Reset, then push {C=6, err=00, op=0001}. Required: out_valid=1 one cycle later, out_c=6, count=1. Pop, then empty=1 and out_c=0.
- Push 4 entries with C = 1, 2, 3, 4 while out_ready=0. Required: full=1, in_ready=0. A fifth push with C=5 is ignored. Drain order is 1, 2, 3, 4.
- Stream 10 entries with in_valid=1 and out_ready=1 continuously after the first. Required: no bubbles after the first, count stays at 1, and pointers wrap correctly with output 1..10 in order.
- Push the sequence err=01, err=10, err=11, err=00. Required: ovf_cnt=2, div0_cnt=2. Assert clr_stats in the same cycle as an err=01 push; required: ovf_cnt=0 afterwards.
- Push 300 entries with err=01, draining continuously. Required: ovf_cnt saturates at 255 and does not wrap to 0.
- With 3 entries queued, assert rst_n=0 asynchronously between clock edges. Required: count=0, empty=1 and out_valid=0 immediately. After release, the next push/pop behaves as after a fresh reset.
